c64_keyboard_matrix: RTL and testbench
======================================

Name: c64_keyboard_matrix

Overview:
- Converts a PS/2 keyboard (scancode set 2) into the C64 8x8 key matrix.
- Sits directly upstream of CIA#1 port B. The CIA's port-A output drives column select into this block.
- This block returns the row lines to the CIA's port-B input.
- It also drives a RESTORE level for the NMI logic.

Parameters:
- TIMEOUT_CYCLES, 32768: clk cycles with no PS/2 falling edge before a partial frame is discarded.
- FILTER_LEN, 4: consecutive equal synchronized samples required before ps2_clk is accepted as a new level.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_ps2_clk  in  1  raw PS/2 clock, asynchronous.
- i_ps2_data  in  1  raw PS/2 data, asynchronous.
- i_pa  in  8  column select from the CIA port A; a bit at 0 selects that column.
- o_pb  out  8  row lines to the CIA port B; a bit at 0 means a key is pressed in a selected column.
- o_restore  out  1  high while RESTORE (PS/2 Page Up) is held.
- o_frame_err  out  1  one-cycle pulse on a parity, start or stop error.

Behaviour:
- Reset, asynchronous, active-low:
  - key state (64 bits) = 0; o_restore = 0; o_frame_err = 0; decoder in IDLE; receiver bit count = 0.
  - With no keys pressed, o_pb = 8'hFF.
- Synchronizer and filter:
  - i_ps2_clk and i_ps2_data each pass through 2 flops.
  - ps2_clk is filtered: its level changes only after FILTER_LEN identical samples.
  - A falling edge of the filtered clock samples the synchronized data.
- PS/2 receiver, one 11-bit frame:
  - Bit order: start=0, then 8 data bits LSB first, then odd parity, then stop=1.
  - A byte-valid pulse fires 1 cycle after the stop bit is sampled, only when start, parity and stop are all correct.
  - Otherwise o_frame_err pulses and the byte is dropped.
  - The timeout counter resets on every falling edge. When it reaches TIMEOUT_CYCLES with the bit count != 0, the bit count returns to 0 with no error pulse.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: on 0xE0 go to EXT; on 0xF0 go to BRK; any other byte is a make of a base code, then stay in IDLE.
  - EXT: on 0xF0 go to EXT_BRK; any other byte is a make of an extended code, then go to IDLE.
  - BRK: any byte is a break of a base code, then go to IDLE.
  - EXT_BRK: any byte is a break of an extended code, then go to IDLE.
  - 0xE1 and 0xAA/0xFA/0xEE replies: byte ignored, state unchanged.
- Key mapping:
  - Code to index through the package table; index = col*8 + row.
  - Make sets the key bit; break clears it; unmapped codes are ignored.
  - Normative entries:
    - 0x1C A -> 10
    - 0x12 LSHIFT -> 15
    - 0x59 RSHIFT -> 52
    - 0x5A RETURN -> 1
    - 0x29 SPACE -> 60
    - 0x66 BKSP -> 0 (DEL)
    - 0x05 F1 -> 4
    - ext 0x72 -> 7 (CRSR U/D)
    - ext 0x74 -> 2 (CRSR L/R)
    - ext 0x7D -> o_restore, not in the matrix
- Key state update latency:
  - Updated 1 cycle after byte-valid.
  - Repeated makes (typematic) are idempotent.
- o_pb is purely combinational from the key state and i_pa, with no added latency. The CIA samples it directly.
- Matrix equation:
  - o_pb[r] = AND over c of ~(key[c*8+r] & ~i_pa[c]).
  - With multiple columns selected, their rows AND together; no ghosting is modelled.

Optional Feature:
- Macro: KEYMATRIX_INJECT_EN.
- When defined, three ports are added:
  - i_inj_valid  in  1
  - i_inj_key  in  7  bit6 = down, bits5:0 = index
  - o_inj_ready  out  1
- Inject handshake:
  - The handshake completes when valid and ready are both high.
  - On completion the key bit is set or cleared the next cycle.
  - o_inj_ready is low during the cycle a PS/2-decoded update is applied; PS/2 has priority.
  - i_inj_valid holds until ready.
  - An injected index 63 with down=1 also drives nothing extra.
- When undefined, the ports are absent and the inject logic is removed.

Decomposition:
- Package keymatrix_pkg:
  - scancode constants (E0, F0, E1, BAT replies);
  - decoder state encoding;
  - key index localparams;
  - the scancode-to-index mapping function, returning {valid, index[5:0]} and a restore flag.
- Sub-module ps2_rx: synchronizer, filter, frame shift register, parity check, timeout. It outputs byte-valid, the byte, and the error pulse.
- Top level: decoder FSM, key state, matrix AND network, and the optional inject logic.

Test Plan:
- Send make 0x1C, set i_pa=8'hFD -> o_pb=8'hFB. Then i_pa=8'hFF -> o_pb=8'hFF.
- Send F0 1C -> key 10 cleared; with i_pa=8'hFD, o_pb=8'hFF.
- Hold LSHIFT 0x12 and A 0x1C, i_pa=8'hFD -> o_pb=8'h7B. Send F0 12 -> o_pb=8'hFB.
- Send E0 7D -> o_restore=1. Send E0 F0 7D -> o_restore=0. In both cases, with i_pa=8'h00, o_pb=8'hFF.
- Send a frame with bad parity for 0x29 -> o_frame_err pulses once; key 60 stays clear.
- Send 5 bits, then idle for TIMEOUT_CYCLES+10, then a valid 0x5A frame -> key 1 set; with i_pa=8'hFE, o_pb=8'hFD.
- Assert rst_n=0 mid-frame with keys held -> o_pb=8'hFF immediately, o_restore=0; the next full frame decodes correctly.

Source files
------------

// File: rtl/keymatrix_pkg.sv
// Shared definitions for the C64 keyboard matrix: scancode constants, decoder
// state encoding, matrix key indices and the PS/2 set-2 to matrix mapping.
package keymatrix_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Matrix index = column*8 + row, matching the CIA port A/B wiring.
    localparam logic [5:0] KEY_DEL     = 6'd0;
    localparam logic [5:0] KEY_RETURN  = 6'd1;
    localparam logic [5:0] KEY_CRSR_LR = 6'd2;
    localparam logic [5:0] KEY_F7      = 6'd3;
    localparam logic [5:0] KEY_F1      = 6'd4;
    localparam logic [5:0] KEY_F3      = 6'd5;
    localparam logic [5:0] KEY_F5      = 6'd6;
    localparam logic [5:0] KEY_CRSR_UD = 6'd7;
    localparam logic [5:0] KEY_3       = 6'd8;
    localparam logic [5:0] KEY_W       = 6'd9;
    localparam logic [5:0] KEY_A       = 6'd10;
    localparam logic [5:0] KEY_4       = 6'd11;
    localparam logic [5:0] KEY_Z       = 6'd12;
    localparam logic [5:0] KEY_S       = 6'd13;
    localparam logic [5:0] KEY_E       = 6'd14;
    localparam logic [5:0] KEY_LSHIFT  = 6'd15;
    localparam logic [5:0] KEY_RSHIFT  = 6'd52;
    localparam logic [5:0] KEY_SPACE   = 6'd60;

    typedef struct packed {
        logic       valid;
        logic [5:0] index;
        logic       restore;
    } key_map_t;

    function automatic key_map_t map_scancode(input logic [7:0] code, input logic ext);
        key_map_t m;
        m = '0;
        if (ext) begin
            case (code)
                8'h72:   begin m.valid = 1'b1; m.index = KEY_CRSR_UD; end
                8'h74:   begin m.valid = 1'b1; m.index = KEY_CRSR_LR; end
                8'h7D:   m.restore = 1'b1;
                default: m = '0;
            endcase
        end else begin
            m.valid = 1'b1;
            case (code)
                8'h1C:   m.index = KEY_A;
                8'h12:   m.index = KEY_LSHIFT;
                8'h59:   m.index = KEY_RSHIFT;
                8'h5A:   m.index = KEY_RETURN;
                8'h29:   m.index = KEY_SPACE;
                8'h66:   m.index = KEY_DEL;
                8'h05:   m.index = KEY_F1;
                8'h04:   m.index = KEY_F3;
                8'h03:   m.index = KEY_F5;
                8'h83:   m.index = KEY_F7;
                8'h26:   m.index = KEY_3;
                8'h25:   m.index = KEY_4;
                8'h1D:   m.index = KEY_W;
                8'h1A:   m.index = KEY_Z;
                8'h1B:   m.index = KEY_S;
                8'h24:   m.index = KEY_E;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/c64_keyboard_matrix_ps2_rx.sv
// PS/2 receiver: two-flop synchronizers, clock glitch filter, 11-bit frame
// capture with start/odd-parity/stop checks and a partial-frame timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 32768,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          fall;
    logic          frame_ok;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], i_ps2_clk};
        data_sync_d = {data_sync_q[0], i_ps2_data};
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        to_cnt_d    = to_cnt_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        frame_ok    = 1'b0;

        // Level flips only after FILTER_LEN consecutive samples disagree with it.
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall = filt_clk_q & ~filt_clk_d;

        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                // frame_q: [0]=start, [8:1]=data, [9]=parity; current sample is stop.
                frame_ok  = ~frame_q[0] & (^frame_q[9:1]) & data_sync_q[1];
                valid_d   = frame_ok;
                err_d     = ~frame_ok;
                if (frame_ok) byte_d = frame_q[8:1];
                bit_cnt_d = '0;
            end else begin
                frame_d   = {data_sync_q[1], frame_q[9:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            to_cnt_q    <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_byte_valid = valid_q;
    assign o_byte       = byte_q;
    assign o_frame_err  = err_q;

endmodule

// File: rtl/c64_keyboard_matrix.sv
// PS/2 set-2 keyboard to C64 8x8 key matrix, feeding CIA#1 port B.
// Optional direct key injection port is enabled by defining KEYMATRIX_INJECT_EN.
module c64_keyboard_matrix
    import keymatrix_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32768,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic [7:0] i_pa,
    output logic [7:0] o_pb,
    output logic       o_restore,
`ifdef KEYMATRIX_INJECT_EN
    input  logic       i_inj_valid,
    input  logic [6:0] i_inj_key,
    output logic       o_inj_ready,
`endif
    output logic       o_frame_err
);
    logic       rx_valid;
    logic [7:0] rx_byte;

    dec_state_e state_q, state_d;
    logic [63:0] key_q, key_d;
    logic        restore_q, restore_d;
    logic        is_make;
    logic        apply;
    key_map_t    map;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .o_byte_valid(rx_valid),
        .o_byte      (rx_byte),
        .o_frame_err (o_frame_err)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        restore_d = restore_q;
        is_make   = 1'b1;
        apply     = 1'b0;
        map       = map_scancode(rx_byte, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));

        if (rx_valid && !(rx_byte == SC_PAUSE || rx_byte == SC_BAT_OK ||
                          rx_byte == SC_ACK   || rx_byte == SC_ECHO)) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT)      state_d = ST_EXT;
                    else if (rx_byte == SC_BRK) state_d = ST_BRK;
                    else                        apply   = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        apply   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    is_make = 1'b0;
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (apply) begin
            if (map.restore)    restore_d          = is_make;
            else if (map.valid) key_d[map.index]   = is_make;
        end

`ifdef KEYMATRIX_INJECT_EN
        // Inject handshake: a transfer happens on a cycle with i_inj_valid and
        // o_inj_ready both high; the requester holds valid and data until then.
        if (i_inj_valid && o_inj_ready) key_d[i_inj_key[5:0]] = i_inj_key[6];
`endif
    end

`ifdef KEYMATRIX_INJECT_EN
    // A decoded PS/2 byte owns the key state this cycle.
    assign o_inj_ready = ~rx_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            restore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            restore_q <= restore_d;
        end
    end

    always_comb begin
        o_pb = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (key_q[c*8 + r] && !i_pa[c]) o_pb[r] = 1'b0;
            end
        end
    end

    assign o_restore = restore_q;

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Directed bench for c64_keyboard_matrix: PS/2 frames in, matrix rows and
// RESTORE/frame-error checked against hand-computed values.
module tb_c64_keyboard_matrix;

    localparam int TIMEOUT_CYCLES = 32768;

    logic       clk;
    logic       rst_n;
    logic       i_ps2_clk;
    logic       i_ps2_data;
    logic [7:0] i_pa;
    logic [7:0] o_pb;
    logic       o_restore;
    logic       o_frame_err;
`ifdef KEYMATRIX_INJECT_EN
    logic       i_inj_valid;
    logic [6:0] i_inj_key;
    logic       o_inj_ready;
`endif

    int vec_cnt;
    int err_cnt;
    int frame_err_pulses;

    c64_keyboard_matrix #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .i_pa       (i_pa),
        .o_pb       (o_pb),
        .o_restore  (o_restore),
`ifdef KEYMATRIX_INJECT_EN
        .i_inj_valid(i_inj_valid),
        .i_inj_key  (i_inj_key),
        .o_inj_ready(o_inj_ready),
`endif
        .o_frame_err(o_frame_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_frame_err) frame_err_pulses++;
    end

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the first nbits of an 11-bit frame (bit 0 first).
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_ps2_data = frame[i];
            wait_clks(10);
            i_ps2_clk = 1'b0;
            wait_clks(20);
            i_ps2_clk = 1'b1;
            wait_clks(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_parity);
        logic par;
        par = ~(^b) ^ bad_parity;
        send_bits({1'b1, par, b, 1'b0}, 11);
        i_ps2_data = 1'b1;
        wait_clks(20);
    endtask

    task automatic pb_check(input string tag, input logic [7:0] pa, input logic [7:0] exp);
        @(negedge clk);
        i_pa = pa;
        #1;
        check_vec(tag, o_pb, exp);
    endtask

    initial begin
        int err_before;
        vec_cnt          = 0;
        err_cnt          = 0;
        frame_err_pulses = 0;
        rst_n      = 1'b0;
        i_ps2_clk  = 1'b1;
        i_ps2_data = 1'b1;
        i_pa       = 8'h00;
`ifdef KEYMATRIX_INJECT_EN
        i_inj_valid = 1'b0;
        i_inj_key   = '0;
`endif
        wait_clks(5);
        #1;
        check_vec("reset_pb", o_pb, 8'hFF);
        check_vec("reset_restore", {7'd0, o_restore}, 8'h00);
        check_vec("reset_frame_err", {7'd0, o_frame_err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(5);

        send_byte(8'h1C, 1'b0);
        pb_check("make_a_col1", 8'hFD, 8'hFB);
        pb_check("make_a_nosel", 8'hFF, 8'hFF);

        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        pb_check("break_a", 8'hFD, 8'hFF);

        send_byte(8'h12, 1'b0);
        send_byte(8'h1C, 1'b0);
        pb_check("lshift_a", 8'hFD, 8'h7B);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        pb_check("break_lshift", 8'hFD, 8'hFB);

        // typematic repeat, then a single break clears it
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        pb_check("typematic_break", 8'hFD, 8'hFF);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h7D, 1'b0);
        #1;
        check_vec("restore_make", {7'd0, o_restore}, 8'h01);
        pb_check("restore_not_in_matrix", 8'h00, 8'hFF);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h7D, 1'b0);
        #1;
        check_vec("restore_break", {7'd0, o_restore}, 8'h00);
        pb_check("restore_break_matrix", 8'h00, 8'hFF);

        err_before = frame_err_pulses;
        send_byte(8'h29, 1'b1);
        check_vec("parity_err_pulses", 8'(frame_err_pulses - err_before), 8'h01);
        pb_check("parity_space_clear", 8'h7F, 8'hFF);

        send_bits(11'h7FE, 5);
        i_ps2_data = 1'b1;
        wait_clks(TIMEOUT_CYCLES + 10);
        send_byte(8'h5A, 1'b0);
        pb_check("timeout_return", 8'hFE, 8'hFD);

        send_byte(8'h1C, 1'b0);
        pb_check("multi_col_and", 8'h00, 8'hF9);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h7D, 1'b0);
        #1;
        check_vec("restore_before_reset", {7'd0, o_restore}, 8'h01);
        send_bits(11'h652, 3);
        i_pa = 8'h00;
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("midframe_reset_pb", o_pb, 8'hFF);
        check_vec("midframe_reset_restore", {7'd0, o_restore}, 8'h00);
        wait_clks(3);
        @(negedge clk);
        rst_n      = 1'b1;
        i_ps2_clk  = 1'b1;
        i_ps2_data = 1'b1;
        wait_clks(20);
        send_byte(8'h1C, 1'b0);
        pb_check("after_reset_make_a", 8'hFD, 8'hFB);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
